// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with valid/ready handshakes and a flush.
//
// Takes one op per cycle from the reservation station. The result is
// computed combinationally and captured in stage 0. Stages 1..STAGES-1
// only delay the result. The last stage drives the out_* ports, so an op
// accepted in cycle t appears on out_valid in cycle t+STAGES.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst            synchronous reset, active-low
//   flush          kills every in-flight op (branch mispredict)
//   in_valid       op presented by the reservation station
//   in_ready       pipe can accept an op this cycle
//   in_op          5-bit opcode
//   in_a, in_b     XLEN-bit operands
//   in_tag         ROB destination tag
//   in_is_branch   op resolves a branch
//   out_valid      result held at the output
//   out_ready      ROB/CDB consumes the result
//   out_result     XLEN-bit result (0 for an illegal opcode)
//   out_tag        tag of the result
//   out_is_branch  copy of in_is_branch
//   out_illegal    opcode was not recognised
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_is_branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_is_branch,
    output logic             out_illegal
);

    localparam int SH_W = $clog2(XLEN);
    localparam int LAST = STAGES - 1;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_AND  = 5'b00001,
        OP_OR   = 5'b00010,
        OP_SLL  = 5'b00011,
        OP_SRL  = 5'b00100,
        OP_SLT  = 5'b00101,
        OP_SLTU = 5'b00110,
        OP_SRA  = 5'b00111,
        OP_SUB  = 5'b01000,
        OP_XOR  = 5'b01001,
        OP_EQ   = 5'b01010,
        OP_GE   = 5'b01011,
        OP_NE   = 5'b01100,
        OP_GEU  = 5'b01101,
        OP_JALR = 5'b10001,
        OP_LT   = 5'b11010,
        OP_LTU  = 5'b11011
    } op_e;

    op_e             op_sel;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;

    logic [STAGES-1:0] valid_q;
    logic [XLEN-1:0]   result_q  [STAGES];
    logic [TAG_W-1:0]  tag_q     [STAGES];
    logic              branch_q  [STAGES];
    logic              illegal_q [STAGES];

    logic [STAGES-1:0] can_load;
    logic              chain;
    logic              accept;

    assign op_sel = op_e'(in_op);
    assign shamt  = in_b[SH_W-1:0];

    // Turns a compare outcome into a zero-extended 0/1 result.
    function automatic logic [XLEN-1:0] flag(input logic c);
        return {{(XLEN-1){1'b0}}, c};
    endfunction

    // Combinational ALU. Unknown opcodes produce a zero result and raise
    // the illegal flag, which travels down the pipe with the result.
    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (op_sel)
            OP_ADD, OP_JALR: alu_result = in_a + in_b;
            OP_SUB:          alu_result = in_a - in_b;
            OP_AND:          alu_result = in_a & in_b;
            OP_OR:           alu_result = in_a | in_b;
            OP_XOR:          alu_result = in_a ^ in_b;
            OP_SLL:          alu_result = in_a << shamt;
            OP_SRL:          alu_result = in_a >> shamt;
            OP_SRA:          alu_result = $unsigned($signed(in_a) >>> shamt);
            OP_SLT, OP_LT:   alu_result = flag($signed(in_a) < $signed(in_b));
            OP_SLTU, OP_LTU: alu_result = flag(in_a < in_b);
            OP_GE:           alu_result = flag($signed(in_a) >= $signed(in_b));
            OP_GEU:          alu_result = flag(in_a >= in_b);
            OP_EQ:           alu_result = flag(in_a == in_b);
            OP_NE:           alu_result = flag(in_a != in_b);
            default:         alu_illegal = 1'b1;
        endcase
    end

    // A stage can take new contents when it, or any stage after it, is
    // empty, or when the output is being consumed. Walking from the last
    // stage backwards gives every stage's answer without a combinational
    // loop through the per-stage terms.
    always_comb begin
        chain    = out_ready;
        can_load = '0;
        for (int k = LAST; k >= 0; k--) begin
            chain       = chain | ~valid_q[k];
            can_load[k] = chain;
        end
    end

    assign in_ready = rst & ~flush & can_load[0];
    assign accept   = in_valid & in_ready;

    // Pipeline state. Valid bits advance when the next slot can take them.
    // Data registers only load when a real op moves in, so the output data
    // holds still during stalls and bubbles. Reset clears everything and
    // takes priority over flush. Flush clears only the valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                result_q[k]  <= '0;
                tag_q[k]     <= '0;
                branch_q[k]  <= 1'b0;
                illegal_q[k] <= 1'b0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (can_load[0]) begin
                    valid_q[0] <= accept;
                end
                for (int k = 1; k < STAGES; k++) begin
                    if (can_load[k]) begin
                        valid_q[k] <= valid_q[k-1];
                    end
                end
            end
            if (accept) begin
                result_q[0]  <= alu_result;
                tag_q[0]     <= in_tag;
                branch_q[0]  <= in_is_branch;
                illegal_q[0] <= alu_illegal;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (can_load[k] && valid_q[k-1]) begin
                    result_q[k]  <= result_q[k-1];
                    tag_q[k]     <= tag_q[k-1];
                    branch_q[k]  <= branch_q[k-1];
                    illegal_q[k] <= illegal_q[k-1];
                end
            end
        end
    end

    assign out_valid     = valid_q[LAST];
    assign out_result    = result_q[LAST];
    assign out_tag       = tag_q[LAST];
    assign out_is_branch = branch_q[LAST];
    assign out_illegal   = illegal_q[LAST];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe.
//
// The bench models the pipe as an ordered list of in-flight ops, each with
// the cycle it was accepted. The oldest op shows on the output STAGES
// cycles after acceptance. The pipe can accept an op while it holds fewer
// than STAGES ops, or while the output is being consumed. Every cycle the
// DUT outputs are compared with this model. Directed cases check
// hand-computed results. A long randomized run follows.
module tb_alu_pipe;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 3;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             in_is_branch;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_is_branch;
    logic             out_illegal;

    alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_is_branch(in_is_branch),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             br;
        logic             ill;
        int unsigned      t;
    } item_t;

    item_t       q[$];
    int unsigned nowCycle   = 0;
    int          checks     = 0;
    int          failures   = 0;
    int          obsOut     = 0;
    bit          afterReset = 1'b0;
    bit          expIn;
    bit          expOV;
    bit          lastAccepted;

    logic [4:0] legalOps [17] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                  5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                  5'b01000, 5'b01001, 5'b01010, 5'b01011,
                                  5'b01100, 5'b01101, 5'b10001, 5'b11010,
                                  5'b11011};

    // Reference ALU written directly from the opcode table.
    function automatic void refAlu(input logic [4:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b,
                                   output logic [XLEN-1:0] r, output logic ill);
        logic [$clog2(XLEN)-1:0] sh;
        logic signed [XLEN-1:0]  sa;
        logic signed [XLEN-1:0]  sb;
        logic                    c;
        sh  = b[$clog2(XLEN)-1:0];
        sa  = a;
        sb  = b;
        r   = '0;
        ill = 1'b0;
        c   = 1'b0;
        case (op)
            5'b00000, 5'b10001: r = a + b;
            5'b01000: r = a - b;
            5'b00001: r = a & b;
            5'b00010: r = a | b;
            5'b01001: r = a ^ b;
            5'b00011: r = a << sh;
            5'b00100: r = a >> sh;
            5'b00111: r = sa >>> sh;
            5'b00101, 5'b11010: c = sa < sb;
            5'b00110, 5'b11011: c = a < b;
            5'b01011: c = sa >= sb;
            5'b01101: c = a >= b;
            5'b01010: c = a == b;
            5'b01100: c = a != b;
            default:  ill = 1'b1;
        endcase
        if (c) r = {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, nowCycle);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [4:0] op,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [TAG_W-1:0] tag, input bit br);
        in_valid     = v;
        in_op        = op;
        in_a         = a;
        in_b         = b;
        in_tag       = tag;
        in_is_branch = br;
    endtask

    // One clock cycle: compare against the model at the falling edge, then
    // advance the model at the rising edge using the same inputs.
    task automatic stepCycle();
        item_t it;
        @(negedge clk);
        expIn = rst && !flush && (q.size() < STAGES || out_ready);
        expOV = (q.size() > 0) && (nowCycle >= q[0].t + STAGES - 1);
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expIn});
        checkOutput("out_valid", {63'd0, out_valid}, {63'd0, expOV});
        if (expOV) begin
            checkOutput("out_result", 64'(out_result), 64'(q[0].res));
            checkOutput("out_tag", 64'(out_tag), 64'(q[0].tag));
            checkOutput("out_is_branch", {63'd0, out_is_branch}, {63'd0, q[0].br});
            checkOutput("out_illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
        end
        if (afterReset) begin
            checkOutput("reset_result", 64'(out_result), 64'd0);
            checkOutput("reset_tag", 64'(out_tag), 64'd0);
            checkOutput("reset_branch", {63'd0, out_is_branch}, 64'd0);
            checkOutput("reset_illegal", {63'd0, out_illegal}, 64'd0);
        end
        if (out_valid && out_ready) obsOut++;
        @(posedge clk);
        nowCycle++;
        lastAccepted = 1'b0;
        if (!rst) begin
            q.delete();
            afterReset = 1'b1;
        end else begin
            afterReset = 1'b0;
            if (expOV && out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_valid && expIn) begin
                refAlu(in_op, in_a, in_b, it.res, it.ill);
                it.tag = in_tag;
                it.br  = in_is_branch;
                it.t   = nowCycle;
                q.push_back(it);
                lastAccepted = 1'b1;
            end
        end
        #1;
    endtask

    // Single op into an empty pipe with out_ready=1; checks the latency and
    // the result against a hand-computed value.
    task automatic directedOp(input string name, input logic [4:0] op,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [TAG_W-1:0] tag, input bit br,
                              input logic [XLEN-1:0] expRes, input bit expIll);
        out_ready = 1'b1;
        flush     = 1'b0;
        applyStimulus(1'b1, op, a, b, tag, br);
        stepCycle();
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            checkOutput({name, "_early"}, {63'd0, out_valid}, 64'd0);
            stepCycle();
        end
        checkOutput({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        checkOutput({name, "_result"}, 64'(out_result), 64'(expRes));
        checkOutput({name, "_tag"}, 64'(out_tag), 64'(tag));
        checkOutput({name, "_branch"}, {63'd0, out_is_branch}, {63'd0, br});
        checkOutput({name, "_illegal"}, {63'd0, out_illegal}, {63'd0, expIll});
        stepCycle();
    endtask

    function automatic logic [XLEN-1:0] randWord();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(XLEN-1){1'b0}}};
            3:       return XLEN'($urandom_range(0, 70));
            default: return XLEN'({$urandom, $urandom});
        endcase
    endfunction

    initial begin
        int cyc;
        int startOut;
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, '0, '0, '0, 1'b0);

        // Reset state
        repeat (3) stepCycle();
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        stepCycle();

        // Basic ops and corner cases
        directedOp("add", 5'b00000, 32'd5, 32'd7, 3'd3, 1'b0, 32'd12, 1'b0);
        directedOp("sub", 5'b01000, 32'd0, 32'd1, 3'd1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        directedOp("sra", 5'b00111, 32'h8000_0000, 32'd4, 3'd2, 1'b0, 32'hF800_0000, 1'b0);
        directedOp("sll33", 5'b00011, 32'd1, 32'd33, 3'd4, 1'b0, 32'd2, 1'b0);
        directedOp("slt", 5'b00101, 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b1, 32'd1, 1'b0);
        directedOp("sltu", 5'b00110, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b1, 32'd0, 1'b0);
        directedOp("geu", 5'b01101, 32'd1, 32'd1, 3'd7, 1'b1, 32'd1, 1'b0);
        directedOp("jalr", 5'b10001, 32'd100, 32'd24, 3'd0, 1'b0, 32'd124, 1'b0);
        directedOp("illegal", 5'b11111, 32'd9, 32'd9, 3'd1, 1'b0, 32'd0, 1'b1);

        // Eight back-to-back ops, output stalled in cycles 3..6
        begin
            int issued;
            issued   = 0;
            cyc      = 0;
            startOut = obsOut;
            while ((issued < 8 || q.size() > 0) && cyc < 100) begin
                out_ready = !(cyc >= 3 && cyc <= 6);
                applyStimulus(issued < 8, 5'b00000, XLEN'(issued * 10), XLEN'(1),
                              TAG_W'(issued), issued[0]);
                #1;
                if (cyc == 6) checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
                stepCycle();
                if (lastAccepted) issued++;
                cyc++;
            end
            checkOutput("burst_done", {63'd0, cyc < 100}, 64'd1);
            checkOutput("burst_count", 64'(obsOut - startOut), 64'd8);
        end

        // Flush with two ops in flight and a third offered
        out_ready = 1'b1;
        applyStimulus(1'b1, 5'b00001, 32'hF0, 32'h3C, 3'd1, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 5'b00010, 32'hF0, 32'h0F, 3'd2, 1'b0);
        stepCycle();
        flush = 1'b1;
        applyStimulus(1'b1, 5'b00000, 32'd1, 32'd1, 3'd7, 1'b0);
        #1;
        checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd0);
        stepCycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (STAGES + 2) stepCycle();

        // Reset during a stall with a result held at the output
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'b01001, 32'hAAAA_0000, 32'h0000_5555, 3'd6, 1'b1);
        stepCycle();
        in_valid = 1'b0;
        repeat (STAGES) stepCycle();
        checkOutput("prereset_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("prereset_result", 64'(out_result), 64'hAAAA_5555);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
        stepCycle();
        checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_result", 64'(out_result), 64'd0);
        checkOutput("rst_tag", 64'(out_tag), 64'd0);
        checkOutput("rst_branch", {63'd0, out_is_branch}, 64'd0);
        rst = 1'b1;
        stepCycle();
        directedOp("post_rst", 5'b01100, 32'd3, 32'd4, 3'd5, 1'b1, 32'd1, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 8000; i++) begin
            rst       = ($urandom_range(0, 299) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            applyStimulus($urandom_range(0, 9) < 7,
                          ($urandom_range(0, 9) == 0) ? 5'($urandom) : legalOps[$urandom_range(0, 16)],
                          randWord(), randWord(), TAG_W'($urandom), 1'($urandom));
            stepCycle();
        end

        // Drain
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        cyc       = 0;
        while (q.size() > 0 && cyc < 20) begin
            stepCycle();
            cyc++;
        end
        checkOutput("drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
